// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered LSU loads onto the single register
// file write port, tracks outstanding loads and raises a decode stall for uncommitted operands.
module writeback_arbiter #(
    parameter int XLEN         = 32,
    parameter int RA_W         = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [RA_W-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RA_W-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic            issue_is_load,
    input  logic [RA_W-1:0] issue_rd,
    input  logic [RA_W-1:0] query_rs0,
    input  logic [RA_W-1:0] query_rs1,
    output logic            stall,
    output logic            rf_write_enable,
    output logic [RA_W-1:0] rf_write_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic            alu_hold,
    output logic            err_alu_ovr
);

    localparam int NREG  = 1 << RA_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_LAST = STV_W'(STARVE_LIMIT - 1);

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_mem [FIFO_DEPTH];
    wb_entry_t        head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NREG-1:0]  pending_q, pending_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic             rf_we_q, rf_we_d;
    logic [RA_W-1:0]  rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]  rf_data_q, rf_data_d;
    logic             hold_q, hold_d;
    logic             err_q, err_d;

    logic             fifo_nonempty;
    logic             push;
    logic             pop;
    logic             stall_rs0;
    logic             stall_rs1;

    // Handshake and arbitration. The ALU is never back-pressured, so it always wins;
    // alu_hold only asks upstream to back off, it does not change the priority here.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        fifo_nonempty = (count_q != '0);
        // Gated by reset so every output reads 0 while reset is held.
        lsu_ready     = rst && (count_q < FULL_CNT);
        push          = lsu_valid && lsu_ready;
        pop           = !alu_valid && fifo_nonempty;
        head          = fifo_mem[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (alu_valid) begin
            rf_we_d   = (alu_rd != '0);
            rf_addr_d = alu_rd;
            rf_data_d = alu_data;
        end else if (fifo_nonempty) begin
            rf_we_d   = (head.rd != '0);
            rf_addr_d = head.rd;
            rf_data_d = head.data;
        end
    end

    // Scoreboard: clear on pop first, then set, so a same-edge set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head.rd] = 1'b0;
        end
        if (issue_valid && issue_is_load && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = '0;
        hold_d   = 1'b0;
        if (alu_valid && fifo_nonempty) begin
            if (starve_q == STARVE_LAST) begin
                hold_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
        err_d = err_q | (alu_valid && hold_q);
    end

    // A register counts as busy while its load is outstanding and also during the cycle
    // its value sits on the write port, since the file only captures it at the next edge.
    always_comb begin
        stall_rs0 = (query_rs0 != '0) &&
                    (pending_q[query_rs0] || (rf_we_q && (rf_addr_q == query_rs0)));
        stall_rs1 = (query_rs1 != '0) &&
                    (pending_q[query_rs1] || (rf_we_q && (rf_addr_q == query_rs1)));
        stall     = stall_rs0 || stall_rs1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            hold_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q guards every read, so
    // stale contents are never observed and the array can map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{rd: lsu_rd, data: lsu_data};
        end
    end

    assign rf_write_enable = rf_we_q;
    assign rf_write_addr   = rf_addr_q;
    assign rf_write_data   = rf_data_q;
    assign alu_hold        = hold_q;
    assign err_alu_ovr     = err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter: ALU path, load path, FIFO full,
// starvation hold/override, x0 handling, scoreboard set-wins and mid-operation reset.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic        issue_is_load;
    logic [4:0]  issue_rd;
    logic [4:0]  query_rs0;
    logic [4:0]  query_rs1;
    logic        stall;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        alu_hold;
    logic        err_alu_ovr;

    int n_checks = 0;
    int n_errors = 0;

    writeback_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .issue_valid     (issue_valid),
        .issue_is_load   (issue_is_load),
        .issue_rd        (issue_rd),
        .query_rs0       (query_rs0),
        .query_rs1       (query_rs1),
        .stall           (stall),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .alu_hold        (alu_hold),
        .err_alu_ovr     (err_alu_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        lsu_valid     = 1'b0;
        lsu_rd        = '0;
        lsu_data      = '0;
        issue_valid   = 1'b0;
        issue_is_load = 1'b0;
        issue_rd      = '0;
        query_rs0     = '0;
        query_rs1     = '0;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, "_we"}, rf_write_enable, we);
        check({tag, "_addr"}, rf_write_addr, addr);
        check({tag, "_data"}, rf_write_data, data);
    endtask

    initial begin
        idle();
        rst = 1'b0;

        // Reset state
        #12;
        check_rf("rst", 1'b0, 5'd0, 32'h0);
        check("rst_ready", lsu_ready, 1'b0);
        check("rst_hold", alu_hold, 1'b0);
        check("rst_err", err_alu_ovr, 1'b0);
        check("rst_stall", stall, 1'b0);
        rst = 1'b1;
        #1;
        check("rel_ready", lsu_ready, 1'b1);
        step();

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        check_rf("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        alu_valid = 1'b0;
        query_rs1 = 5'd5;
        #1;
        check("alu_stall_rs1", stall, 1'b1);
        step();
        check_rf("alu_idle", 1'b0, 5'd5, 32'hDEADBEEF);
        check("alu_idle_stall", stall, 1'b0);
        idle();

        // Load path with scoreboard
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0; query_rs0 = 5'd7;
        #1;
        check("ld_pend_stall", stall, 1'b1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
        step();
        lsu_valid = 1'b0;
        #1;
        check("ld_accept_we", rf_write_enable, 1'b0);
        check("ld_accept_stall", stall, 1'b1);
        step();
        check_rf("ld_pop", 1'b1, 5'd7, 32'h1234);
        check("ld_pop_stall", stall, 1'b1);
        step();
        check("ld_done_we", rf_write_enable, 1'b0);
        check("ld_done_stall", stall, 1'b0);
        idle();

        // FIFO full while the ALU keeps winning
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA1;
        #1;
        check("full_rdy_a", lsu_ready, 1'b1);
        step();
        lsu_rd = 5'd11; lsu_data = 32'hB2;
        check("full_rdy_b", lsu_ready, 1'b1);
        step();
        lsu_rd = 5'd12; lsu_data = 32'hC3;
        check("full_rdy_c", lsu_ready, 1'b0);
        alu_data = 32'h101;
        step();
        check("full_still", lsu_ready, 1'b0);
        check_rf("full_alu", 1'b1, 5'd1, 32'h101);
        alu_valid = 1'b0;
        step();
        check_rf("full_pop_a", 1'b1, 5'd10, 32'hA1);
        check("full_rdy_after_pop", lsu_ready, 1'b1);
        step();
        check_rf("full_pop_b", 1'b1, 5'd11, 32'hB2);
        lsu_valid = 1'b0;
        step();
        check_rf("full_pop_c", 1'b1, 5'd12, 32'hC3);
        step();
        check("full_drained_we", rf_write_enable, 1'b0);
        idle();

        // Starvation: hold raised after the fourth ALU win with a waiting load
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h200;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h55;
        step();
        lsu_valid = 1'b0;
        step();
        step();
        step();
        check("starve_hold_3", alu_hold, 1'b0);
        step();
        check("starve_hold_4", alu_hold, 1'b1);
        alu_valid = 1'b0;
        step();
        check_rf("starve_yield", 1'b1, 5'd20, 32'h55);
        check("starve_hold_pulse", alu_hold, 1'b0);
        check("starve_no_err", err_alu_ovr, 1'b0);
        idle();

        // Starvation again, but the ALU ignores the hold
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h200;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h66;
        step();
        lsu_valid = 1'b0;
        step();
        step();
        step();
        step();
        check("ovr_hold", alu_hold, 1'b1);
        alu_rd = 5'd3; alu_data = 32'h300;
        step();
        check("ovr_err", err_alu_ovr, 1'b1);
        check_rf("ovr_alu_wins", 1'b1, 5'd3, 32'h300);
        alu_valid = 1'b0;
        step();
        check_rf("ovr_pop", 1'b1, 5'd21, 32'h66);
        step();
        check("ovr_err_sticky", err_alu_ovr, 1'b1);
        idle();

        // x0 destinations
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd0;
        step();
        check("x0_alu_we", rf_write_enable, 1'b0);
        check("x0_stall", stall, 1'b0);
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h88;
        step();
        lsu_rd = 5'd3; lsu_data = 32'h33;
        step();
        lsu_valid = 1'b0;
        check("x0_lsu_we", rf_write_enable, 1'b0);
        step();
        check_rf("x0_next_entry", 1'b1, 5'd3, 32'h33);
        step();
        idle();

        // Scoreboard: re-issue on the popping edge keeps the register pending
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd9;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        lsu_valid = 1'b0;
        step();
        issue_valid = 1'b0; query_rs0 = 5'd9;
        check_rf("sw_pop", 1'b1, 5'd9, 32'h99);
        step();
        check("sw_set_wins", stall, 1'b1);
        lsu_valid = 1'b1; lsu_data = 32'h98;
        step();
        lsu_valid = 1'b0;
        step();
        check_rf("sw_pop2", 1'b1, 5'd9, 32'h98);
        step();
        check("sw_cleared", stall, 1'b0);
        idle();

        // Mid-operation asynchronous reset
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h400;
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd13;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD;
        step();
        issue_rd = 5'd14; lsu_rd = 5'd14; lsu_data = 32'hE;
        step();
        issue_valid = 1'b0; lsu_valid = 1'b0;
        query_rs0 = 5'd13; query_rs1 = 5'd14;
        #1;
        check("mr_pre_ready", lsu_ready, 1'b0);
        check("mr_pre_we", rf_write_enable, 1'b1);
        #2;
        rst = 1'b0;
        alu_valid = 1'b0;
        #1;
        check_rf("mr_rst", 1'b0, 5'd0, 32'h0);
        check("mr_ready", lsu_ready, 1'b0);
        check("mr_stall", stall, 1'b0);
        check("mr_err", err_alu_ovr, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("mr_rel_ready", lsu_ready, 1'b1);
        step();
        check("mr_no_stale_1", rf_write_enable, 1'b0);
        step();
        check("mr_no_stale_2", rf_write_enable, 1'b0);
        check("mr_rel_stall", stall, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
